// File: rtl/counter_sweep_pkg.sv
// Shared types for the counter sweep controller family.
// Holds the FSM state encoding and the cycle-counter width helper.
package counter_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    // Width needed to hold 0..timeout inclusive.
    function automatic int cyc_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_TIMEOUT = 32;
    localparam int DEF_CYC_W   = cyc_w(DEF_TIMEOUT);

endpackage

// File: rtl/sweep_budget_timer.sv
// Cycle budget counter with clear, enable and terminal-count flag.
// Terminal count is raised while the counter sits at TIMEOUT-1.
module sweep_budget_timer
    import counter_sweep_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CW      = cyc_w(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cycles,
    output logic          tc
);

    logic [CW-1:0] cycles_q;
    logic [CW-1:0] cycles_d;

    // Next count: clear has priority over advancing.
    always_comb begin
        cycles_d = cycles_q;
        if (clr) begin
            cycles_d = '0;
        end else if (en) begin
            cycles_d = cycles_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
    assign tc     = (cycles_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequences a counter sweep and reports hit or timeout per sweep.
// Carries its own cover/assert properties on the hit event.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32,
    parameter int HITW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           init,
    input  logic [WIDTH-1:0]           step,
    input  logic [WIDTH-1:0]           target,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic                       timeout,
    output logic [WIDTH-1:0]           count,
    output logic [cyc_w(TIMEOUT)-1:0]  cycles,
    output logic [HITW-1:0]            hit_count
);

    localparam int CW = cyc_w(TIMEOUT);

    sweep_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             hit_q, hit_d;
    logic             timeout_q, timeout_d;
    logic [HITW-1:0]  hit_count_q, hit_count_d;
    logic             busy_q, done_q;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [CW-1:0]    tmr_cycles;

    sweep_budget_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .cycles (tmr_cycles),
        .tc     (tmr_tc)
    );

    // Sweep FSM next-state and datapath; abort > hit > timeout > advance.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        step_d      = step_q;
        target_d    = target_q;
        hit_d       = hit_q;
        timeout_d   = timeout_q;
        hit_count_d = hit_count_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    count_d   = init;
                    step_d    = step;
                    target_d  = target;
                    hit_d     = 1'b0;
                    timeout_d = 1'b0;
                    tmr_clr   = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (count_q == target_q) begin
                    state_d = DONE;
                    hit_d   = 1'b1;
                    if (hit_count_q != '1) begin
                        hit_count_d = hit_count_q + 1'b1;
                    end
                end else if (tmr_tc) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    count_d = count_q + step_q;
                    tmr_en  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            step_q      <= '0;
            target_q    <= '0;
            hit_q       <= 1'b0;
            timeout_q   <= 1'b0;
            hit_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            step_q      <= step_d;
            target_q    <= target_d;
            hit_q       <= hit_d;
            timeout_q   <= timeout_d;
            hit_count_q <= hit_count_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign timeout   = timeout_q;
    assign count     = count_q;
    assign cycles    = tmr_cycles;
    assign hit_count = hit_count_q;

    cov_hit_rise: cover property (
        @(posedge clk) disable iff (rst) $rose(hit_q));

    a_done_pulse: assert property (
        @(posedge clk) disable iff (rst) done_q |=> !done_q);

    a_flag_excl: assert property (
        @(posedge clk) disable iff (rst) !(hit_q && timeout_q));

    a_busy_state: assert property (
        @(posedge clk) disable iff (rst) busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: closed-form sweep model checked every
// cycle, plus directed sweeps with hand-computed literal expectations.
module tb_counter_sweep_ctrl;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 32;
    localparam int HITW    = 8;
    localparam int CW      = $clog2(TIMEOUT + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] init = '0;
    logic [WIDTH-1:0] step = '0;
    logic [WIDTH-1:0] target = '0;
    logic             busy, done, hit, timeout;
    logic [WIDTH-1:0] count;
    logic [CW-1:0]    cycles;
    logic [HITW-1:0]  hit_count;

    int n_tests = 0;
    int n_fail  = 0;

    counter_sweep_ctrl #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .HITW    (HITW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .init      (init),
        .step      (step),
        .target    (target),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .timeout   (timeout),
        .count     (count),
        .cycles    (cycles),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    // Model state: sweep described by its start values and its end cycle.
    logic             m_busy = 0, m_done = 0, m_hit = 0, m_to = 0;
    logic [WIDTH-1:0] m_count = '0;
    logic [CW-1:0]    m_cyc = '0;
    logic [HITW-1:0]  m_hc = '0;
    int               m_n = 0, m_end = 0, m_init = 0, m_step = 0;
    bit               m_hcase = 0;

    // Find first k in the budget where init+k*step == target (mod 2**W).
    task automatic plan(input int i, input int s, input int t,
                        output int e, output bit h);
        h = 0;
        e = TIMEOUT;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (((i + k * s) % (1 << WIDTH)) == t) begin
                e = k + 1;
                h = 1;
                break;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_hit = 0; m_to = 0;
            m_count = '0; m_cyc = '0; m_hc = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_init = int'(init);
                m_step = int'(step);
                plan(m_init, m_step, int'(target), m_end, m_hcase);
                m_n = 0;
                m_busy = 1; m_hit = 0; m_to = 0;
                m_count = init;
                m_cyc = '0;
            end
        end else if (m_done) begin
            m_busy = 0;
            m_done = 0;
        end else if (abort) begin
            m_busy = 0;
        end else begin
            m_n++;
            if (m_n == m_end) begin
                m_done = 1;
                if (m_hcase) begin
                    m_hit = 1;
                    if (m_hc != '1) m_hc = m_hc + 1'b1;
                end else begin
                    m_to = 1;
                end
            end else begin
                m_count = WIDTH'(m_init + m_n * m_step);
                m_cyc = CW'(m_n);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        n_tests++;
        if ({busy, done, hit, timeout, count, cycles, hit_count} !==
            {m_busy, m_done, m_hit, m_to, m_count, m_cyc, m_hc}) begin
            n_fail++;
            $display("FAIL model t=%0t got b=%0b d=%0b h=%0b to=%0b c=%0d cy=%0d hc=%0d exp b=%0b d=%0b h=%0b to=%0b c=%0d cy=%0d hc=%0d",
                     $time, busy, done, hit, timeout, count, cycles,
                     hit_count, m_busy, m_done, m_hit, m_to, m_count,
                     m_cyc, m_hc);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Start a sweep from IDLE and return posedges from start edge to done.
    task automatic run(input int i, input int s, input int t,
                       output int lat);
        repeat (2) @(negedge clk);
        init = WIDTH'(i);
        step = WIDTH'(s);
        target = WIDTH'(t);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_wait got=none exp=pulse");
        end
    endtask

    task automatic chk_end(input string tag, input int lat, input int e_lat,
                           input int e_hit, input int e_to, input int e_cnt,
                           input int e_cyc, input int e_hc);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_hit"}, int'(hit), e_hit);
        check({tag, "_to"}, int'(timeout), e_to);
        check({tag, "_count"}, int'(count), e_cnt);
        check({tag, "_cycles"}, int'(cycles), e_cyc);
        check({tag, "_hc"}, int'(hit_count), e_hc);
        @(posedge clk);
        #1;
        check({tag, "_done_off"}, int'(done), 0);
        check({tag, "_busy_off"}, int'(busy), 0);
    endtask

    initial begin
        int lat;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_to", int'(timeout), 0);
        check("rst_count", int'(count), 0);
        check("rst_cycles", int'(cycles), 0);
        check("rst_hc", int'(hit_count), 0);

        run(0, 1, 15, lat);
        chk_end("up15", lat, 16, 1, 0, 15, 15, 1);

        run(1, 2, 4, lat);
        chk_end("unreach", lat, 32, 0, 1, 15, 31, 1);

        run(14, 3, 1, lat);
        chk_end("wrap", lat, 2, 1, 0, 1, 1, 2);

        run(9, 4, 9, lat);
        chk_end("immed", lat, 1, 1, 0, 9, 0, 3);

        run(5, 0, 6, lat);
        chk_end("step0", lat, 32, 0, 1, 5, 31, 3);

        // Abort at count 5 with a stray start while busy.
        repeat (2) @(negedge clk);
        init = 4'd0; step = 4'd1; target = 4'd15;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ab_pre_count", int'(count), 5);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("ab_busy", int'(busy), 0);
        check("ab_done", int'(done), 0);
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ab_idle", int'(busy), 0);
        check("ab_count", int'(count), 5);
        check("ab_cycles", int'(cycles), 5);
        check("ab_hit", int'(hit), 0);
        check("ab_hc", int'(hit_count), 3);

        // Asynchronous reset between edges mid-sweep.
        repeat (2) @(negedge clk);
        init = 4'd0; step = 4'd1; target = 4'd15;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("ar_pre_count", int'(count), 7);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", int'(busy), 0);
        check("ar_count", int'(count), 0);
        check("ar_cycles", int'(cycles), 0);
        check("ar_hc", int'(hit_count), 0);
        @(negedge clk);
        rst = 1'b0;

        run(3, 1, 6, lat);
        chk_end("post_rst", lat, 4, 1, 0, 6, 3, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
